// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the show-ahead FIFO burst reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        HOLD  = 2'd2
    } rd_burst_st_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-stage valid/ready output register carrying data with sop/eop sideband.
module stream_out_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (ld) begin
            valid_d = 1'b1;
            data_d  = in_data;
            sop_d   = in_sop;
            eop_d   = in_eop;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;

endmodule

// File: rtl/fifo1c_burst_rd.sv
// Drains a show-ahead FIFO into framed sop/eop bursts, started by fill level,
// residue timeout or flush request.
module fifo1c_burst_rd
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_usedw,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [STAT_WIDTH-1:0] burst_cnt,
    output logic [STAT_WIDTH-1:0] short_cnt,
    output logic                  underflow_err
);

    localparam int unsigned UW   = ADDR_WIDTH + 1;
    localparam int unsigned TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    rd_burst_st_e          state_q, state_d;
    logic [UW-1:0]         rem_q, rem_d;
    logic [UW-1:0]         len_q, len_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  flush_done_q, flush_done_d;
    logic [STAT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [STAT_WIDTH-1:0] short_cnt_q, short_cnt_d;
    logic                  underflow_q, underflow_d;

    logic can_issue, rdreq, eop_acc, residue, tmo_hit, start, flush_now;
    logic ld_sop, ld_eop;

    // Reset also blocks the pop so words in the FIFO survive a mid-burst reset.
    assign can_issue = (state_q == BURST) && (rem_q != '0) && (!out_valid || out_ready) && !rst;
    assign rdreq     = can_issue && !fifo_empty;
    assign eop_acc   = (state_q == HOLD) && out_valid && out_ready;
    assign residue   = (fifo_usedw != '0) && (fifo_usedw < UW'(BURST_LEN));
    assign tmo_hit   = (TIMEOUT != 0) && (timer_q == TW'(TMAX));
    assign start     = !fifo_empty && ((fifo_usedw >= UW'(BURST_LEN)) || tmo_hit || flush_pend_q);
    assign flush_now = (flush_pend_q || flush_req) && (state_q == IDLE) && fifo_empty && !out_valid;
    assign ld_sop    = (rem_q == len_q);
    assign ld_eop    = (rem_q == UW'(1));

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        len_d        = len_q;
        timer_d      = '0;
        flush_pend_d = (flush_pend_q || flush_req) && !flush_now;
        flush_done_d = flush_now;
        burst_cnt_d  = burst_cnt_q;
        short_cnt_d  = short_cnt_q;
        underflow_d  = underflow_q || (can_issue && fifo_empty);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BURST;
                    rem_d   = UW'(min_u(32'(fifo_usedw), BURST_LEN));
                    len_d   = UW'(min_u(32'(fifo_usedw), BURST_LEN));
                end else if (residue) begin
                    timer_d = (timer_q == TW'(TMAX)) ? timer_q : timer_q + TW'(1);
                end
            end
            BURST: begin
                if (rdreq) begin
                    rem_d = rem_q - UW'(1);
                    if (rem_q == UW'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (eop_acc) begin
                    state_d     = IDLE;
                    burst_cnt_d = burst_cnt_q + STAT_WIDTH'(1);
                    if (len_q < UW'(BURST_LEN)) begin
                        short_cnt_d = short_cnt_q + STAT_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            len_q        <= '0;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            burst_cnt_q  <= '0;
            short_cnt_q  <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            timer_q      <= timer_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            burst_cnt_q  <= burst_cnt_d;
            short_cnt_q  <= short_cnt_d;
            underflow_q  <= underflow_d;
        end
    end

    stream_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .ld        (rdreq),
        .in_data   (fifo_q),
        .in_sop    (ld_sop),
        .in_eop    (ld_eop),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    assign fifo_rdreq    = rdreq;
    assign flush_done    = flush_done_q;
    assign burst_cnt     = burst_cnt_q;
    assign short_cnt     = short_cnt_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo1c_burst_rd.sv
// Directed bench for fifo1c_burst_rd with a depth-4 show-ahead FIFO model.
module tb_fifo1c_burst_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_q;
    logic        fifo_empty;
    logic [2:0]  fifo_usedw;
    logic        fifo_rdreq;
    logic [7:0]  out_data;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready;
    logic        flush_req;
    logic        flush_done;
    logic [15:0] burst_cnt, short_cnt;
    logic        underflow_err;

    always #5 clk = ~clk;

    fifo1c_burst_rd dut (
        .clk(clk), .rst(rst),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
        .fifo_rdreq(fifo_rdreq),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready),
        .flush_req(flush_req), .flush_done(flush_done),
        .burst_cnt(burst_cnt), .short_cnt(short_cnt), .underflow_err(underflow_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // FIFO model: registered status, show-ahead head word
    logic [7:0] fq[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       force_empty = 1'b0;
    logic [7:0] fifo_q_r = 8'h00;
    logic       fifo_empty_r = 1'b1;
    logic [2:0] usedw_r = 3'd0;

    assign fifo_q     = fifo_q_r;
    assign fifo_empty = fifo_empty_r | force_empty;
    assign fifo_usedw = usedw_r;

    // Monitor logs, all maintained at the rising edge
    int         cyc = 0;
    logic [7:0] cap_data[$];
    bit         cap_sop[$];
    bit         cap_eop[$];
    int         acc_cyc[$];
    int         pop_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         first_push_cyc = 0;
    int         last_push_cyc = 0;
    int         stall_err = 0;
    int         stall_seen = 0;
    bit         stall_prev = 1'b0;
    logic [9:0] held = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (stall_prev && ({out_valid, out_sop, out_data} !== held)) stall_err++;
        if (rst) stall_prev = 1'b0;
        else     stall_prev = out_valid && !out_ready;
        if (stall_prev) stall_seen++;
        held = {out_valid, out_sop, out_data};
        if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_sop.push_back(out_sop);
            cap_eop.push_back(out_eop);
            acc_cyc.push_back(cyc);
        end
        if (flush_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (fifo_rdreq) begin
            pop_cyc.push_back(cyc);
            if (fq.size() > 0) void'(fq.pop_front());
        end
        if (wr_en) begin
            if (fq.size() == 0) first_push_cyc = cyc;
            last_push_cyc = cyc;
            fq.push_back(wr_data);
        end
        fifo_q_r     <= (fq.size() > 0) ? fq[0] : 8'h00;
        fifo_empty_r <= (fq.size() == 0);
        usedw_r      <= 3'(fq.size());
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        cap_data.delete(); cap_sop.delete(); cap_eop.delete();
        acc_cyc.delete(); pop_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 200 && fq.size() >= 4; g++) begin
                wr_en = 1'b0;
                @(negedge clk);
            end
            wr_en   = 1'b1;
            wr_data = 8'(base + 8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int bound);
        for (int k = 0; k < bound && cap_data.size() < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] got[9];
        string       nm[9];
        rst = 1'b1; out_ready = 1'b1; flush_req = 1'b0;
        tick(3);
        got = '{16'(fifo_rdreq), 16'(out_valid), 16'(out_data), 16'(out_sop), 16'(out_eop),
                16'(flush_done), burst_cnt, short_cnt, 16'(underflow_err)};
        nm  = '{"rst_rdreq", "rst_valid", "rst_data", "rst_sop", "rst_eop",
                "rst_flush_done", "rst_burst_cnt", "rst_short_cnt", "rst_underflow"};
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (got[i] !== 16'd0) begin
                n_bad++;
                $display("FAIL %s: got %0h expected 0", nm[i], got[i]);
            end
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_full_burst();
        clear_logs();
        push_seq(8'hA0, 4);
        wait_caps(4, 60);
        tick(3);
        n_cmp++;
        if (cap_data.size() !== 4 || pop_cyc.size() !== 4) begin
            n_bad++;
            $display("FAIL full_count: got %0d words %0d pops expected 4 4", cap_data.size(), pop_cyc.size());
        end else begin
            n_cmp++;
            if (pop_cyc[0] !== last_push_cyc + 2) begin
                n_bad++;
                $display("FAIL full_first_pop: got cycle %0d expected %0d", pop_cyc[0], last_push_cyc + 2);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (cap_data[i] !== 8'(8'hA0 + 8'(i)) || cap_sop[i] !== (i == 0) || cap_eop[i] !== (i == 3)
                    || acc_cyc[i] !== pop_cyc[0] + i + 1 || pop_cyc[i] !== pop_cyc[0] + i) begin
                    n_bad++;
                    $display("FAIL full_word%0d: got %h sop%0d eop%0d acc%0d pop%0d expected %h sop%0d eop%0d acc%0d pop%0d",
                             i, cap_data[i], cap_sop[i], cap_eop[i], acc_cyc[i], pop_cyc[i],
                             8'(8'hA0 + 8'(i)), i == 0, i == 3, pop_cyc[0] + i + 1, pop_cyc[0] + i);
                end
            end
        end
        n_cmp++;
        if (burst_cnt !== 16'd1 || short_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL full_counters: got %0d/%0d expected 1/0", burst_cnt, short_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        push_seq(8'hB0, 2);
        wait_caps(2, 60);
        tick(3);
        n_cmp++;
        if (cap_data.size() !== 2 || pop_cyc.size() !== 2) begin
            n_bad++;
            $display("FAIL tmo_count: got %0d words expected 2", cap_data.size());
        end else begin
            // decision on the 16th non-empty idle cycle, first pop one cycle later
            n_cmp++;
            if (pop_cyc[0] !== first_push_cyc + 17) begin
                n_bad++;
                $display("FAIL tmo_start: got cycle %0d expected %0d", pop_cyc[0], first_push_cyc + 17);
            end
            n_cmp++;
            if (cap_data[0] !== 8'hB0 || cap_sop[0] !== 1'b1 || cap_eop[0] !== 1'b0
                || cap_data[1] !== 8'hB1 || cap_sop[1] !== 1'b0 || cap_eop[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL tmo_words: got %h/%0d%0d %h/%0d%0d expected b0/10 b1/01",
                         cap_data[0], cap_sop[0], cap_eop[0], cap_data[1], cap_sop[1], cap_eop[1]);
            end
        end
        n_cmp++;
        if (burst_cnt !== 16'd2 || short_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL tmo_counters: got %0d/%0d expected 2/1", burst_cnt, short_cnt);
        end
    endtask

    task automatic test_stall();
        clear_logs();
        stall_err = 0;
        stall_seen = 0;
        fork
            push_seq(8'hC0, 9);
            begin
                for (int k = 0; k < 400 && cap_data.size() < 9; k++) begin
                    out_ready = (k % 2 == 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        tick(4);
        n_cmp++;
        if (cap_data.size() !== 9) begin
            n_bad++;
            $display("FAIL stall_count: got %0d words expected 9", cap_data.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_cmp++;
                if (cap_data[i] !== 8'(8'hC0 + 8'(i)) || cap_sop[i] !== (i == 0 || i == 4 || i == 8)
                    || cap_eop[i] !== (i == 3 || i == 7 || i == 8)) begin
                    n_bad++;
                    $display("FAIL stall_word%0d: got %h sop%0d eop%0d expected %h sop%0d eop%0d",
                             i, cap_data[i], cap_sop[i], cap_eop[i], 8'(8'hC0 + 8'(i)),
                             i == 0 || i == 4 || i == 8, i == 3 || i == 7 || i == 8);
                end
            end
        end
        n_cmp++;
        if (stall_err !== 0 || stall_seen == 0) begin
            n_bad++;
            $display("FAIL stall_stable: got %0d unstable of %0d stalls expected 0 of >0", stall_err, stall_seen);
        end
        n_cmp++;
        if (burst_cnt !== 16'd5 || short_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL stall_counters: got %0d/%0d expected 5/2", burst_cnt, short_cnt);
        end
    endtask

    task automatic test_flush();
        clear_logs();
        push_seq(8'hF0, 3);
        flush_req = 1'b1; tick(1);
        flush_req = 1'b0; tick(1);
        flush_req = 1'b1; tick(1);   // repeat while pending is absorbed
        flush_req = 1'b0;
        wait_caps(3, 40);
        tick(6);
        n_cmp++;
        if (cap_data.size() !== 3) begin
            n_bad++;
            $display("FAIL flush_count: got %0d words expected 3", cap_data.size());
        end else begin
            n_cmp++;
            if (cap_data[0] !== 8'hF0 || cap_sop[0] !== 1'b1 || cap_eop[0] !== 1'b0
                || cap_data[2] !== 8'hF2 || cap_sop[2] !== 1'b0 || cap_eop[2] !== 1'b1) begin
                n_bad++;
                $display("FAIL flush_frame: got %h/%0d%0d %h/%0d%0d expected f0/10 f2/01",
                         cap_data[0], cap_sop[0], cap_eop[0], cap_data[2], cap_sop[2], cap_eop[2]);
            end
            // pulse is high during the cycle after the first idle+empty cycle
            n_cmp++;
            if (done_cnt !== 1 || done_cyc !== acc_cyc[2] + 2) begin
                n_bad++;
                $display("FAIL flush_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, acc_cyc[2] + 2);
            end
        end
        n_cmp++;
        if (burst_cnt !== 16'd6 || short_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL flush_counters: got %0d/%0d expected 6/3", burst_cnt, short_cnt);
        end
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        n_cmp++;
        if (flush_done !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_empty_next: got %0d expected 1", flush_done);
        end
        tick(1);
        n_cmp++;
        if (flush_done !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_empty_single: got %0d expected 0", flush_done);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_logs();
        push_seq(8'hD0, 4);
        for (int k = 0; k < 60 && pop_cyc.size() < 2; k++) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        tick(1);
        n_cmp++;
        if ({fifo_rdreq, out_valid, out_sop, out_eop, flush_done, underflow_err} !== 6'd0
            || out_data !== 8'h00 || burst_cnt !== 16'd0 || short_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got rd%0d v%0d s%0d e%0d fd%0d uf%0d d%h b%0d s%0d expected all 0",
                     fifo_rdreq, out_valid, out_sop, out_eop, flush_done, underflow_err, out_data, burst_cnt, short_cnt);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        wait_caps(3, 60);
        tick(3);
        n_cmp++;
        if (cap_data.size() !== 3) begin
            n_bad++;
            $display("FAIL midrst_count: got %0d words expected 3", cap_data.size());
        end else begin
            n_cmp++;
            if (cap_data[0] !== 8'hD0 || cap_sop[0] !== 1'b1
                || cap_data[1] !== 8'hD2 || cap_sop[1] !== 1'b1 || cap_eop[1] !== 1'b0
                || cap_data[2] !== 8'hD3 || cap_sop[2] !== 1'b0 || cap_eop[2] !== 1'b1) begin
                n_bad++;
                $display("FAIL midrst_words: got %h %h/%0d%0d %h/%0d%0d expected d0 d2/10 d3/01",
                         cap_data[0], cap_data[1], cap_sop[1], cap_eop[1], cap_data[2], cap_sop[2], cap_eop[2]);
            end
        end
        n_cmp++;
        if (burst_cnt !== 16'd1 || short_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL midrst_counters: got %0d/%0d expected 1/1", burst_cnt, short_cnt);
        end
    endtask

    task automatic test_underflow();
        clear_logs();
        push_seq(8'hE0, 2);
        flush_req = 1'b1; tick(1);
        flush_req = 1'b0; tick(1);
        force_empty = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rdreq !== 1'b0) begin
            n_bad++;
            $display("FAIL uf_no_rdreq: got %0d expected 0", fifo_rdreq);
        end
        tick(1);
        n_cmp++;
        if (underflow_err !== 1'b1) begin
            n_bad++;
            $display("FAIL uf_set: got %0d expected 1", underflow_err);
        end
        tick(5);
        n_cmp++;
        if (underflow_err !== 1'b1 || pop_cyc.size() !== 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL uf_hold: got err%0d pops%0d valid%0d expected 1 0 0", underflow_err, pop_cyc.size(), out_valid);
        end
        force_empty = 1'b0;
        wait_caps(2, 40);
        tick(2);
        n_cmp++;
        if (cap_data.size() !== 2 || cap_data[0] !== 8'hE0 || cap_sop[0] !== 1'b1
            || cap_data[1] !== 8'hE1 || cap_eop[1] !== 1'b1 || underflow_err !== 1'b1) begin
            n_bad++;
            $display("FAIL uf_resume: got %0d words err%0d expected e0 sop, e1 eop, err1", cap_data.size(), underflow_err);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++;
        if (underflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL uf_clear: got %0d expected 0", underflow_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        flush_req = 1'b0;
        test_reset();
        test_full_burst();
        test_timeout();
        test_stall();
        test_flush();
        test_reset_mid_burst();
        test_underflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
